// File: rtl/ft245_device_emulator.sv
// FT245 chip-side model: answers an FPGA FT245 controller over rd_n/wr_n strobes and
// bridges the bytes to host-side valid/ready streams through two small FIFOs.
module ft245_device_emulator #(
  parameter int RX_DEPTH             = 16,
  parameter int TX_DEPTH             = 16,
  parameter int RXF_PRECHARGE_CYCLES = 3,
  parameter int TXE_PRECHARGE_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rd_n,
  output logic                      rxf_n,
  output logic [7:0]                data_out,
  output logic                      data_oe,
  input  logic                      wr_n,
  output logic                      txe_n,
  input  logic [7:0]                data_in,
  input  logic [7:0]                host_tx_data,
  input  logic                      host_tx_valid,
  output logic                      host_tx_ready,
  output logic [7:0]                host_rx_data,
  output logic                      host_rx_valid,
  input  logic                      host_rx_ready,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic [$clog2(TX_DEPTH):0] tx_count,
  output logic                      protocol_err
);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RCW = $clog2(RXF_PRECHARGE_CYCLES + 1);
  localparam int WCW = $clog2(TXE_PRECHARGE_CYCLES + 1);
  localparam logic [RAW:0]   RX_FULL = (RAW+1)'(RX_DEPTH);
  localparam logic [RAW:0]   RX_ONE  = (RAW+1)'(1);
  localparam logic [TAW:0]   TX_FULL = (TAW+1)'(TX_DEPTH);
  localparam logic [RCW-1:0] RC_LOAD = RCW'(RXF_PRECHARGE_CYCLES - 1);
  localparam logic [WCW-1:0] WC_LOAD = WCW'(TXE_PRECHARGE_CYCLES - 1);

  typedef enum logic [1:0] {R_IDLE, R_ACTIVE, R_PRECHG} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_PRECHG} wr_state_t;

  // ---------------- strobe synchronizers ([0] meta, [1] sync, [2] edge ref)
  logic [2:0] rd_sync, wr_sync, arm;
  logic       rd_fall, rd_rise, wr_fall, wr_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sync <= 3'b111;
      wr_sync <= 3'b111;
      arm     <= 3'b000;
    end else begin
      rd_sync <= {rd_sync[1:0], rd_n};
      wr_sync <= {wr_sync[1:0], wr_n};
      arm     <= {arm[1:0], 1'b1};
    end
  end

  // A strobe held low across reset must not look like a fresh edge once the
  // forced-high synchronizers refill, so edges are ignored until they settle.
  assign rd_fall = arm[2] &  rd_sync[2] & ~rd_sync[1];
  assign rd_rise = arm[2] & ~rd_sync[2] &  rd_sync[1];
  assign wr_fall = arm[2] &  wr_sync[2] & ~wr_sync[1];
  assign wr_rise = arm[2] & ~wr_sync[2] &  wr_sync[1];

  assign data_oe = ~rd_n & ~rst;

  // ---------------- RX FIFO (host -> controller)
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp, rx_rp_inc;
  logic [RAW:0]   rx_count_nxt;
  logic           rx_push, rx_pop;
  logic [7:0]     rx_head, rx_next;

  assign rx_push   = host_tx_valid & host_tx_ready;
  assign rx_rp_inc = rx_rp + 1'b1;
  assign rx_head   = rx_mem[rx_rp];
  assign rx_next   = rx_mem[rx_rp_inc];

  always_comb begin
    rx_count_nxt = rx_count;
    if (rx_push && !rx_pop)      rx_count_nxt = rx_count + 1'b1;
    else if (!rx_push && rx_pop) rx_count_nxt = rx_count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp         <= '0;
      rx_rp         <= '0;
      rx_count      <= '0;
      host_tx_ready <= 1'b0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp_inc;
      rx_count      <= rx_count_nxt;
      host_tx_ready <= (rx_count_nxt != RX_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= host_tx_data;
  end

  // ---------------- read FSM
  rd_state_t      r_state, r_nxt;
  logic [RCW-1:0] rcnt, rcnt_nxt;
  logic           rd_ok, rd_ok_nxt, rxf_n_nxt, rd_err;
  logic [7:0]     data_out_nxt;

  always_comb begin
    r_nxt        = r_state;
    rcnt_nxt     = rcnt;
    rd_ok_nxt    = rd_ok;
    rxf_n_nxt    = 1'b1;
    data_out_nxt = data_out;
    rx_pop       = 1'b0;
    rd_err       = 1'b0;
    unique case (r_state)
      R_IDLE: begin
        rxf_n_nxt = (rx_count == '0);
        if (rx_count != '0) data_out_nxt = rx_head;
        if (rd_fall) begin
          r_nxt     = R_ACTIVE;
          rxf_n_nxt = 1'b1;
          rd_ok_nxt = (rx_count != '0);
          rd_err    = (rx_count == '0);
        end
      end
      R_ACTIVE: begin
        if (rd_rise) begin
          r_nxt    = R_PRECHG;
          rcnt_nxt = RC_LOAD;
          rx_pop   = rd_ok;
          if (rd_ok && rx_count != RX_ONE) data_out_nxt = rx_next;
        end
      end
      R_PRECHG: begin
        if (rcnt == '0) r_nxt = R_IDLE;
        else            rcnt_nxt = rcnt - 1'b1;
      end
      default: r_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= R_IDLE;
      rcnt     <= '0;
      rd_ok    <= 1'b0;
      rxf_n    <= 1'b1;
      data_out <= '0;
    end else begin
      r_state  <= r_nxt;
      rcnt     <= rcnt_nxt;
      rd_ok    <= rd_ok_nxt;
      rxf_n    <= rxf_n_nxt;
      data_out <= data_out_nxt;
    end
  end

  // ---------------- TX FIFO (controller -> host), first-word fall-through
  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic           tx_push, tx_pop, tx_room;

  assign host_rx_valid = (tx_count != '0);
  assign host_rx_data  = tx_mem[tx_rp];
  assign tx_pop        = host_rx_valid & host_rx_ready;
  assign tx_room       = (tx_count != TX_FULL) | tx_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_count <= tx_count + 1'b1;
      else if (!tx_push && tx_pop) tx_count <= tx_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= data_in;
  end

  // ---------------- write FSM; data_in is captured when the falling edge is seen
  wr_state_t      w_state, w_nxt;
  logic [WCW-1:0] wcnt, wcnt_nxt;
  logic           txe_n_nxt, wr_err;

  always_comb begin
    w_nxt     = w_state;
    wcnt_nxt  = wcnt;
    txe_n_nxt = 1'b1;
    tx_push   = 1'b0;
    wr_err    = 1'b0;
    unique case (w_state)
      W_IDLE: begin
        txe_n_nxt = (tx_count == TX_FULL);
        if (wr_fall) begin
          w_nxt     = W_ACTIVE;
          txe_n_nxt = 1'b1;
          tx_push   = tx_room;
          wr_err    = ~tx_room;
        end
      end
      W_ACTIVE: begin
        if (wr_rise) begin
          w_nxt    = W_PRECHG;
          wcnt_nxt = WC_LOAD;
        end
      end
      W_PRECHG: begin
        if (wcnt == '0) w_nxt = W_IDLE;
        else            wcnt_nxt = wcnt - 1'b1;
      end
      default: w_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state      <= W_IDLE;
      wcnt         <= '0;
      txe_n        <= 1'b1;
      protocol_err <= 1'b0;
    end else begin
      w_state      <= w_nxt;
      wcnt         <= wcnt_nxt;
      txe_n        <= txe_n_nxt;
      protocol_err <= protocol_err | rd_err | wr_err;
    end
  end

endmodule

// File: tb/tb_ft245_device_emulator.sv
// Bench for ft245_device_emulator: acts as the FT245 controller and the host, with
// queue-based reference FIFOs and monitors that check every byte the DUT presents.
module tb_ft245_device_emulator;
  localparam int DEPTH = 16;

  logic       clk = 1'b0, rst = 1'b1;
  logic       rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0] data_in = '0, host_tx_data = '0;
  logic       host_tx_valid = 1'b0, host_rx_ready = 1'b0;
  logic       rxf_n, data_oe, txe_n, host_tx_ready, host_rx_valid, protocol_err;
  logic [7:0] data_out, host_rx_data;
  logic [4:0] rx_count, tx_count;

  ft245_device_emulator dut (
    .clk(clk), .rst(rst), .rd_n(rd_n), .rxf_n(rxf_n), .data_out(data_out), .data_oe(data_oe),
    .wr_n(wr_n), .txe_n(txe_n), .data_in(data_in), .host_tx_data(host_tx_data),
    .host_tx_valid(host_tx_valid), .host_tx_ready(host_tx_ready), .host_rx_data(host_rx_data),
    .host_rx_valid(host_rx_valid), .host_rx_ready(host_rx_ready), .rx_count(rx_count),
    .tx_count(tx_count), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // reference model: bytes the controller should read, bytes the host should receive
  byte unsigned rx_q[$], tx_q[$];
  bit  exp_err = 1'b0;
  int  n_checks = 0, n_pass = 0, rd_seen = 0, hrx_seen = 0;
  logic rd_n_q = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    n_checks++;
    $display("FAIL %s: got timeout expected DUT event", name);
  endtask

  // controller-side monitor: byte on the bus when the read strobe starts
  always @(negedge clk) begin
    if (!rst && rd_n_q && !rd_n) begin
      chk("data_oe", data_oe, 1);
      chk("rd_avail", int'(rx_q.size() != 0), 1);
      if (rx_q.size() != 0) begin
        chk("data_out", data_out, rx_q.pop_front());
        rd_seen++;
      end
    end
    rd_n_q = rd_n;
  end

  // host-side monitor: byte popped on valid & ready
  always @(negedge clk) begin
    if (!rst && host_rx_valid && host_rx_ready) begin
      chk("hrx_avail", int'(tx_q.size() != 0), 1);
      if (tx_q.size() != 0) begin
        chk("host_rx_data", host_rx_data, tx_q.pop_front());
        hrx_seen++;
      end
    end
  end

  task automatic host_push(input byte unsigned d);
    int t = 0;
    @(posedge clk); #1;
    host_tx_data  = d;
    host_tx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (host_tx_ready) break;
      if (++t > 2000) break;
    end
    if (t > 2000) tmo("host_push");
    else begin
      rx_q.push_back(d);
      @(posedge clk); #1;
    end
    host_tx_valid = 1'b0;
  endtask

  task automatic ctl_read();
    int t = 0;
    do begin @(negedge clk); t++; end while (rxf_n && t < 2000);
    if (rxf_n) tmo("ctl_read");
    else begin
      @(posedge clk); #1 rd_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rd_n = 1'b1;
    end
  endtask

  task automatic ctl_write(input byte unsigned d, input bit force_it);
    int t = 0;
    if (force_it) repeat (12) @(posedge clk);
    else begin
      do begin @(negedge clk); t++; end while (txe_n && t < 2000);
      if (txe_n) begin tmo("ctl_write"); return; end
    end
    @(posedge clk); #1;
    data_in = d;
    wr_n    = 1'b0;
    if (tx_q.size() < DEPTH) tx_q.push_back(d);
    else exp_err = 1'b1;
    repeat (4) @(posedge clk);
    #1 wr_n = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    rx_q.delete(); tx_q.delete(); exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, cyc;
    bit done;
    // reset values, then ready/txe one cycle after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rxf_n", rxf_n, 1);
    chk("rst_txe_n", txe_n, 1);
    chk("rst_htx_ready", host_tx_ready, 0);
    chk("rst_hrx_valid", host_rx_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_err", protocol_err, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("post_rxf_n", rxf_n, 1);
    chk("post_txe_n", txe_n, 0);
    chk("post_htx_ready", host_tx_ready, 1);
    chk("post_rx_count", rx_count, 0);
    chk("post_tx_count", tx_count, 0);

    // host pushes two bytes, controller reads one, precharge timing, next head
    host_push(8'hA5);
    host_push(8'h3C);
    ctl_read();
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (rxf_n && cyc < 50);
    chk("rxf_prechg_hold", int'(cyc >= 5 && !rxf_n), 1);
    chk("next_head", data_out, rx_q[0]);
    chk("rx_count_after_rd", rx_count, rx_q.size());
    ctl_read();

    // single controller write to host
    ctl_write(8'h5A, 1'b0);
    t = 0;
    do begin @(negedge clk); t++; end while (!host_rx_valid && t < 50);
    if (!host_rx_valid) tmo("hrx_valid");
    chk("tx_count_one", tx_count, tx_q.size());
    chk("hrx_head", host_rx_data, tx_q[0]);
    @(posedge clk); #1 host_rx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 host_rx_ready = 1'b0;
    @(negedge clk);
    chk("tx_count_drained", tx_count, tx_q.size());

    // randomized concurrent loopback, 64 bytes each way
    rd_seen = 0; hrx_seen = 0; done = 1'b0;
    fork
      for (int i = 0; i < 64; i++) begin
        host_push(8'(i));
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
      for (int i = 0; i < 64; i++) begin
        ctl_read();
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
      for (int i = 0; i < 64; i++) begin
        ctl_write(8'(i), 1'b0);
        repeat ($urandom_range(0, 4)) @(posedge clk);
      end
      begin
        for (int g = 0; g < 20000 && hrx_seen < 64; g++) begin
          @(posedge clk); #1 host_rx_ready = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1 host_rx_ready = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("loop_rd_seen", rd_seen, 64);
    chk("loop_hrx_seen", hrx_seen, 64);
    chk("loop_rx_count", rx_count, rx_q.size());
    chk("loop_tx_count", tx_count, tx_q.size());
    chk("loop_err", protocol_err, exp_err);

    // fill TX FIFO, then a forced write into a full FIFO is dropped
    for (int i = 0; i < DEPTH; i++) ctl_write(8'($urandom_range(0, 255)), 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("full_txe_n", txe_n, 1);
    chk("full_tx_count", tx_count, tx_q.size());
    ctl_write(8'hEE, 1'b1);
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("drop_err", protocol_err, exp_err);
    chk("drop_tx_count", tx_count, tx_q.size());
    hrx_seen = 0;
    @(posedge clk); #1 host_rx_ready = 1'b1;
    repeat (DEPTH + 4) @(posedge clk);
    #1 host_rx_ready = 1'b0;
    @(negedge clk);
    chk("drain_seen", hrx_seen, DEPTH);
    chk("drain_tx_count", tx_count, tx_q.size());

    // reset during a read strobe aborts it; release after reset is harmless
    do_reset();
    host_push(8'h77);
    t = 0;
    do begin @(negedge clk); t++; end while (rxf_n && t < 50);
    if (rxf_n) tmo("rst_rd_rxf");
    @(posedge clk); #1 rd_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    rx_q.delete(); tx_q.delete(); exp_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrd_rx_count", rx_count, rx_q.size());
    chk("midrd_rxf_n", rxf_n, 1);
    chk("midrd_data_oe", data_oe, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rd_n = 1'b1;
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("postrd_rx_count", rx_count, rx_q.size());
    chk("postrd_err", protocol_err, exp_err);
    chk("postrd_rxf_n", rxf_n, 1);
    rd_seen = 0;
    host_push(8'h42);
    ctl_read();
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("postrd_read_ok", rd_seen, 1);
    chk("postrd_final_count", rx_count, rx_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
